// File: rtl/rv_fetch_unit.sv
// RV32I instruction-fetch front end: owns the PC, issues pipelined fetches to a
// variable-latency memory, and buffers in-order responses for decode.
module rv_fetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst_data,
   output logic [XLEN-1:0] inst_pc,
   output logic            halted
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   discard_q, discard_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic            halted_q, halted_d;
   logic [31:0]     data_q [DEPTH];
   logic [31:0]     data_d [DEPTH];
   logic [XLEN-1:0] pcs_q  [DEPTH];
   logic [XLEN-1:0] pcs_d  [DEPTH];

   logic [CW:0]     occupancy;
   logic            req_fire;
   logic            rsp_keep;
   logic            deq;
   logic [XLEN-1:0] redirect_base;

   // Discarded in-flight fetches still hold credit, so occupancy never exceeds DEPTH.
   always_comb begin
      occupancy      = {1'b0, count_q} + {1'b0, inflight_q};
      imem_req_valid = !rst && !halted_q && !redirect_valid &&
                       (occupancy < (CW+1)'(DEPTH));
      imem_req_addr  = fetch_pc_q;
      inst_valid     = (count_q != '0);
      inst_data      = data_q[rd_ptr_q];
      inst_pc        = pcs_q[rd_ptr_q];
      halted         = halted_q;
      req_fire       = imem_req_valid && imem_req_ready;
      deq            = inst_valid && inst_ready;
      rsp_keep       = imem_rsp_valid && !redirect_valid && (discard_q == '0);
      redirect_base  = redirect_pc & ~(XLEN'(3));
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      count_d    = count_q;
      discard_d  = discard_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      halted_d   = halted_q;
      data_d     = data_q;
      pcs_d      = pcs_q;
      inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);

      if (redirect_valid) begin
         fetch_pc_d = redirect_base;
         rsp_pc_d   = redirect_base;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         discard_d  = inflight_d;
         halted_d   = 1'b0;
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
         if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
         if (rsp_keep) begin
            data_d[wr_ptr_q] = imem_rsp_data;
            pcs_d[wr_ptr_q]  = rsp_pc_q;
            wr_ptr_d         = wr_ptr_q + AW'(1);
            rsp_pc_d         = rsp_pc_q + XLEN'(4);
         end
         if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(rsp_keep) - CW'(deq);
         if (halt) halted_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         count_q    <= '0;
         inflight_q <= '0;
         discard_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         halted_q   <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            pcs_q[i]  <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         halted_q   <= halted_d;
         data_q     <= data_d;
         pcs_q      <= pcs_d;
      end
   end

endmodule

// File: doc/rv_fetch_unit.md
Name: rv_fetch_unit

Overview:
Parametrised instruction-fetch front end for the RV32I cores; the next generation of the single-cycle PC/branch-mux/ECALL-hold path.
- Owns the PC and issues pipelined requests to a variable-latency instruction memory.
- Buffers in-order responses in a prefetch queue and hands {instruction, PC} to decode over a valid/ready handshake.
- Supports redirect (branch/jump target from execute) with flush of queued and in-flight fetches, and a sticky halt driven by ECALL.

Parameters:
XLEN, 32, address/PC width.
DEPTH, 4, prefetch queue entries; power of two, >=2; also the cap on queued plus in-flight fetches.
RESET_PC, 0, PC loaded at reset; bits [1:0] must be 0.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-high.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request this cycle.
imem_req_addr  out  XLEN  word-aligned fetch address.
imem_rsp_valid  in  1  response data valid; responses return in request order, at most one per cycle.
imem_rsp_data  in  32  fetched instruction word.
redirect_valid  in  1  single-cycle pulse: restart fetch at redirect_pc.
redirect_pc  in  XLEN  new PC; bits [1:0] ignored (treated as 0).
halt  in  1  ECALL seen; stop issuing fetches.
inst_valid  out  1  queue head valid.
inst_ready  in  1  decode consumes head.
inst_data  out  32  head instruction.
inst_pc  out  XLEN  PC of head instruction.
halted  out  1  sticky halt state.

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, rsp_pc=RESET_PC, queue count=0, inflight=0, discard=0.
  - Outputs at reset: imem_req_valid=0, inst_valid=0, halted=0, inst_data=0, inst_pc=0, imem_req_addr=RESET_PC.
  - Reset mid-operation drops all queued and in-flight state. Responses arriving after release are not discarded; the bench must not return stale responses across reset.
- Issue:
  - imem_req_valid=1 when !halted && !redirect_valid && (count+inflight) < DEPTH.
  - imem_req_addr=fetch_pc.
  - Accept (valid&&ready): fetch_pc += 4 (wraps mod 2^XLEN); inflight += 1.
  - Address is held stable while valid && !ready. The only exception is a redirect, which may withdraw the request.
- Response:
  - If discard>0, the response is dropped and discard -= 1.
  - Otherwise {imem_rsp_data, rsp_pc} is enqueued and rsp_pc += 4.
  - In both cases inflight -= 1.
  - Credit rule guarantees no overflow; enqueue into a full queue is impossible by construction.
- Output:
  - inst_valid = (count>0); inst_data/inst_pc = head entry.
  - Dequeue on inst_valid && inst_ready.
  - No bypass: a response in cycle t is visible at the head no earlier than t+1.
  - Simultaneous enqueue and dequeue keeps count unchanged, including at count=DEPTH-1 and count=DEPTH (dequeue only).
  - Queue pointers wrap mod DEPTH.
- Redirect (redirect_valid=1 in cycle t):
  - At edge t: queue flushed (count=0); fetch_pc and rsp_pc = {redirect_pc[XLEN-1:2],2'b00}.
  - discard = inflight after this cycle's accounting. Any response in cycle t is discarded outright.
  - imem_req_valid=0 in cycle t; inst_valid=0 from t+1.
  - The first request at the new PC is issued in t+1.
  - Redirect clears halted.
  - Redirect has priority over halt and over any same-cycle dequeue.
- Halt:
  - halt=1 (without redirect) sets halted at next edge. No new requests from that edge.
  - A request already accepted still completes and is enqueued; the queue continues to drain to decode.
  - halted clears only on reset or redirect.
- Counters: inflight and discard are $clog2(DEPTH)+1 bits; count is $clog2(DEPTH)+1 bits.

Test Plan:
- Zero-wait memory (ready=1, rsp one cycle after accept), inst_ready=1 -> after reset inst_pc streams 0x0,0x4,0x8,0xC... one per cycle from the 3rd cycle after reset release; data matches memory image.
- inst_ready=0 for 20 cycles, DEPTH=4 -> exactly 4 requests accepted (addr 0x0..0xC); imem_req_valid stays 0 once count+inflight=4; release ready -> 0x0..0xC delivered in order, fetch resumes at 0x10.
- 3-cycle response latency, redirect_pc=0x103 pulsed while 2 fetches in flight and 2 queued -> both late responses dropped, inst_valid=0 next cycle, next delivered inst_pc=0x100, then 0x104.
- imem_req_ready held low with valid high 5 cycles -> imem_req_addr constant throughout; no PC advance until accept.
- halt pulse at PC 0x20 with one fetch in flight -> halted=1 next cycle, no further requests, queued/in-flight instructions delivered, then inst_valid=0 indefinitely; redirect to 0x40 -> halted=0, fetch at 0x40.
- fetch_pc=0xFFFFFFFC (redirect) -> next request address 0x00000000; rst asserted mid-stream asynchronously -> all outputs at reset values before the next clock edge.
